mem_ctrl: RTL

Memory controller that arbitrates the single byte-wide RAM port between the instruction fetcher (word reads) and the load/store buffer (1/2/4-byte reads and writes). It sits directly upstream of the fetcher, serving its one-cycle `ena`/`drop` request protocol and returning a 32-bit instruction with a one-cycle ok pulse. It serialises every access into byte transfers on `mem_a`/`mem_din`/`mem_dout`/`mem_wr`. It also honours fetcher drops, ROB rollbacks and the IO buffer back-pressure.

---
 rtl/mem_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter between the instruction fetcher and the load/store buffer.
// state     | meaning
// IDLE      | waiting; LSB request wins over fetch
// IF_READ   | fetching a 4-byte instruction
// LSB_READ  | LSB read of 1/2/4 bytes
// LSB_WRITE | LSB write of 1/2/4 bytes, IO back-pressure aware
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ena_from_if,
  input  logic [31:0] pc_from_if,
  input  logic        drop_flag_from_if,
  output logic        ok_flag_to_if,
  output logic [31:0] inst_to_if,
  input  logic        ena_from_lsb,
  input  logic        wr_flag_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [1:0]  size_from_lsb,
  input  logic [31:0] data_from_lsb,
  output logic        ok_flag_to_lsb,
  output logic [31:0] data_to_lsb,
  input  logic        rollback_flag_from_rob,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE} state_t;

  state_t      state, state_nxt;
  logic        if_pend, lsb_pend, lsb_wr;
  logic [31:0] if_addr, lsb_addr, lsb_data;
  logic [1:0]  lsb_size;
  logic [31:0] cur_addr, cur_data, rd_buf, cap_word;
  logic [2:0]  cur_len, stage;
  logic [1:0]  lane;
  logic [7:0]  wr_byte;
  logic        wr_reg;
  logic        acc_lsb, acc_if, stall_lsb, stall_cur, rd_abort;

  function automatic logic [2:0] size_len(input logic [1:0] s);
    case (s)
      2'd0:    size_len = 3'd1;
      2'd1:    size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  // A pending read that is rolled back on this edge must not be accepted.
  assign acc_lsb   = (state == IDLE) && lsb_pend && !(rollback_flag_from_rob && !lsb_wr);
  assign acc_if    = (state == IDLE) && !acc_lsb && if_pend && !drop_flag_from_if;
  assign stall_lsb = (lsb_addr[17:16] == IO_HI) && io_buffer_full;
  assign stall_cur = (cur_addr[17:16] == IO_HI) && io_buffer_full;
  assign rd_abort  = ((state == IF_READ) && drop_flag_from_if) ||
                     ((state == LSB_READ) && rollback_flag_from_rob);

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_lsb)     state_nxt = lsb_wr ? LSB_WRITE : LSB_READ;
        else if (acc_if) state_nxt = IF_READ;
      end
      IF_READ, LSB_READ: if (rd_abort || stage == cur_len) state_nxt = IDLE;
      LSB_WRITE:         if (stage == cur_len) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_wr   = wr_reg & rdy;
    lane     = stage[1:0] - 2'd1;
    cap_word = rd_buf;
    cap_word[{lane, 3'b000} +: 8] = mem_din;
    case (stage[1:0])
      2'd0:    wr_byte = cur_data[7:0];
      2'd1:    wr_byte = cur_data[15:8];
      2'd2:    wr_byte = cur_data[23:16];
      default: wr_byte = cur_data[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pend <= 1'b0; if_addr <= '0;
      lsb_pend <= 1'b0; lsb_wr <= 1'b0; lsb_addr <= '0; lsb_size <= '0; lsb_data <= '0;
      cur_addr <= '0; cur_data <= '0; cur_len <= '0; stage <= '0; rd_buf <= '0;
      wr_reg <= 1'b0; mem_a <= '0; mem_dout <= '0;
      ok_flag_to_if <= 1'b0; ok_flag_to_lsb <= 1'b0;
      inst_to_if <= '0; data_to_lsb <= '0;
    end else if (!rdy) begin
      // RAM data seen while frozen is not trusted: re-run the read from its base.
      if (state == IF_READ || state == LSB_READ) begin
        mem_a <= cur_addr;
        stage <= '0;
      end
    end else begin
      ok_flag_to_if  <= 1'b0;
      ok_flag_to_lsb <= 1'b0;

      if (drop_flag_from_if) if_pend <= 1'b0;
      else if (ena_from_if) begin
        if_pend <= 1'b1;
        if_addr <= pc_from_if;
      end else if (acc_if) if_pend <= 1'b0;

      if (ena_from_lsb) begin
        lsb_pend <= 1'b1;
        lsb_wr   <= wr_flag_from_lsb;
        lsb_addr <= addr_from_lsb;
        lsb_size <= size_from_lsb;
        lsb_data <= data_from_lsb;
      end else if (acc_lsb || (rollback_flag_from_rob && !lsb_wr)) lsb_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (acc_lsb) begin
            cur_addr <= lsb_addr;
            cur_data <= lsb_data;
            cur_len  <= size_len(lsb_size);
            rd_buf   <= '0;
            mem_a    <= lsb_addr;
            if (lsb_wr) begin
              mem_dout <= lsb_data[7:0];
              wr_reg   <= !stall_lsb;
              stage    <= stall_lsb ? 3'd0 : 3'd1;
            end else begin
              stage <= '0;
            end
          end else if (acc_if) begin
            cur_addr <= if_addr;
            cur_len  <= 3'd4;
            rd_buf   <= '0;
            mem_a    <= if_addr;
            stage    <= '0;
          end
        end
        IF_READ, LSB_READ: begin
          if (!rd_abort) begin
            mem_a <= mem_a + 32'd1;
            stage <= stage + 3'd1;
            if (stage != 3'd0) rd_buf <= cap_word;
            if (stage == cur_len) begin
              if (state == IF_READ) begin
                inst_to_if    <= cap_word;
                ok_flag_to_if <= 1'b1;
              end else begin
                data_to_lsb    <= cap_word;
                ok_flag_to_lsb <= 1'b1;
              end
            end
          end
        end
        LSB_WRITE: begin
          if (stage == cur_len) begin
            wr_reg         <= 1'b0;
            ok_flag_to_lsb <= 1'b1;
          end else if (stall_cur) begin
            wr_reg <= 1'b0;
          end else begin
            mem_a    <= cur_addr + {29'd0, stage};
            mem_dout <= wr_byte;
            wr_reg   <= 1'b1;
            stage    <= stage + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
